// File: rtl/dmem_responder_pkg.sv
// Shared widths, constants and FSM encoding for the data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned DataBus = 32;
  localparam int unsigned AddrBus = 32;
  localparam int unsigned ByteWEn = 4;

  localparam logic [DataBus-1:0] ZeroWord  = '0;
  localparam logic [ByteWEn-1:0] WrDisable = '0;

  typedef enum logic [1:0] {
    DMS_IDLE = 2'b00,
    DMS_WAIT = 2'b01,
    DMS_DONE = 2'b10
  } dms_state_e;

  // Replace the bytes selected by wen in old_word with the matching lanes of new_word.
  function automatic logic [DataBus-1:0] merge_bytes(input logic [DataBus-1:0] old_word,
                                                     input logic [DataBus-1:0] new_word,
                                                     input logic [ByteWEn-1:0] wen);
    logic [DataBus-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < ByteWEn; i++) begin
      if (wen[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with byte write enables and a registered, write-first read port.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [ByteWEn-1:0] wen_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [DataBus-1:0] wdata_i,
  output logic [DataBus-1:0] rdata_o
);

  logic [DataBus-1:0] mem_q [DEPTH_WORDS];
  logic [DataBus-1:0] rdata_q;
  logic [DataBus-1:0] wr_word;

  assign wr_word = merge_bytes(mem_q[addr_i], wdata_i, wen_i);

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int unsigned i = 0; i < ByteWEn; i++) begin
        if (wen_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Read port returns the post-write word, so a write reports what it stored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= ZeroWord;
    end else if (en_i) begin
      rdata_q <= wr_word;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts one access, stalls for LATENCY+1 cycles, then returns data.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m_en,
  input  logic [ByteWEn-1:0] m_wen,
  input  logic [AddrBus-1:0] m_vaddr,
  input  logic [DataBus-1:0] m_wdata,
  output logic [DataBus-1:0] m_rdata,
  output logic               stallreq
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  dms_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       access;
  logic       stall_raw;
  logic       unused_addr_bits;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DMS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    access    = 1'b0;
    stall_raw = 1'b0;
    unique case (state_q)
      DMS_IDLE: begin
        if (m_en) begin
          stall_raw = 1'b1;
          if (LATENCY == 0) begin
            access  = 1'b1;
            state_d = DMS_DONE;
          end else begin
            cnt_d   = 4'(LATENCY);
            state_d = DMS_WAIT;
          end
        end
      end
      DMS_WAIT: begin
        stall_raw = 1'b1;
        cnt_d     = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          access  = 1'b1;
          state_d = DMS_DONE;
        end
      end
      DMS_DONE: state_d = DMS_IDLE;
      default:  state_d = DMS_IDLE;
    endcase
  end

  // Gate with reset so a request held during reset neither stalls nor writes.
  assign stallreq = stall_raw & rst;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .en_i   (access & rst),
    .wen_i  (m_wen),
    .addr_i (m_vaddr[AW+1:2]),
    .wdata_i(m_wdata),
    .rdata_o(m_rdata)
  );

  assign unused_addr_bits = ^{m_vaddr[AddrBus-1:AW+2], m_vaddr[1:0]};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY=2 and LATENCY=0.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_en, b_en;
  logic [3:0]  a_wen, b_wen;
  logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
  logic [31:0] a_rdata, b_rdata;
  logic        a_stall, b_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst), .m_en(a_en), .m_wen(a_wen), .m_vaddr(a_addr),
    .m_wdata(a_wdata), .m_rdata(a_rdata), .stallreq(a_stall)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut_l0 (
    .clk(clk), .rst(rst), .m_en(b_en), .m_wen(b_wen), .m_vaddr(b_addr),
    .m_wdata(b_wdata), .m_rdata(b_rdata), .stallreq(b_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; leaves m_en high.
  task automatic acc2(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp, input string tag);
    a_wen = wen; a_addr = addr; a_wdata = wdata; a_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check({tag, " stall"}, {31'b0, a_stall}, (c < 3) ? 32'd1 : 32'd0);
      if (c == 3) check({tag, " rdata"}, a_rdata, exp);
      @(posedge clk); #1;
    end
  endtask

  task automatic acc0(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp, input string tag);
    b_wen = wen; b_addr = addr; b_wdata = wdata; b_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check({tag, " stall"}, {31'b0, b_stall}, (c < 1) ? 32'd1 : 32'd0);
      if (c == 1) check({tag, " rdata"}, b_rdata, exp);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input string tag);
    a_en = 1'b0; b_en = 1'b0;
    @(negedge clk);
    check({tag, " idle stall a"}, {31'b0, a_stall}, 32'd0);
    check({tag, " idle stall b"}, {31'b0, b_stall}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    a_en = 1'b1; a_wen = 4'b0000; a_addr = 32'h0; a_wdata = 32'h0;
    b_en = 1'b1; b_wen = 4'b0000; b_addr = 32'h0; b_wdata = 32'h0;

    // Reset held with requests pending
    repeat (2) @(negedge clk);
    check("rst rdata a", a_rdata, 32'h0);
    check("rst stall a", {31'b0, a_stall}, 32'd0);
    check("rst rdata b", b_rdata, 32'h0);
    check("rst stall b", {31'b0, b_stall}, 32'd0);
    @(posedge clk); #1;
    a_en = 1'b0; b_en = 1'b0; rst = 1'b1;
    idle("post-rst");
    idle("post-rst2");

    // Full write, read, byte write
    acc2(4'b1111, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, "wr10");
    idle("wr10");
    acc2(4'b0000, 32'h10, 32'h0, 32'hDEADBEEF, "rd10");
    idle("rd10");
    acc2(4'b0010, 32'h10, 32'h0000AA00, 32'hDEADAAEF, "bytewr");
    idle("bytewr");
    acc2(4'b0000, 32'h10, 32'h0, 32'hDEADAAEF, "byterd");
    idle("byterd");

    // Back-to-back reads with m_en held high throughout
    acc2(4'b1111, 32'h14, 32'hCAFEF00D, 32'hCAFEF00D, "wr14");
    idle("wr14");
    acc2(4'b0000, 32'h10, 32'h0, 32'hDEADAAEF, "b2b0");
    acc2(4'b0000, 32'h14, 32'h0, 32'hCAFEF00D, "b2b1");
    idle("b2b");

    // Address aliasing modulo 4 KiB, low bits ignored
    acc2(4'b1111, 32'h00001010, 32'h12345678, 32'h12345678, "aliaswr");
    idle("aliaswr");
    acc2(4'b0000, 32'h00000013, 32'h0, 32'h12345678, "aliasrd");
    idle("aliasrd");

    // Reset during the WAIT phase of a write drops it
    acc2(4'b1111, 32'h20, 32'h0, 32'h0, "clr20");
    idle("clr20");
    a_wen = 4'b1111; a_addr = 32'h20; a_wdata = 32'h55AA55AA; a_en = 1'b1;
    @(negedge clk);
    check("midrst accept stall", {31'b0, a_stall}, 32'd1);
    @(posedge clk); #2;
    check("midrst wait stall", {31'b0, a_stall}, 32'd1);
    rst = 1'b0; #1;
    check("midrst stall drop", {31'b0, a_stall}, 32'd0);
    check("midrst rdata", a_rdata, 32'h0);
    @(posedge clk); #1;
    a_en = 1'b0; rst = 1'b1;
    idle("midrst");
    acc2(4'b0000, 32'h20, 32'h0, 32'h0, "rd20");
    idle("rd20");

    // Zero-latency instance: one stall cycle per access
    acc0(4'b1111, 32'h30, 32'h0BADF00D, 32'h0BADF00D, "l0wr");
    idle("l0wr");
    acc0(4'b0001, 32'h30, 32'h000000EE, 32'h0BADF0EE, "l0byte");
    acc0(4'b0000, 32'h30, 32'h0, 32'h0BADF0EE, "l0rd");
    idle("l0rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the MEM-stage data-access interface; it answers the m_en/m_wen/m_vaddr/m_wdata request that the EX/MEM pipeline register presents to the MEM stage.
- Each access has a programmable wait latency. It holds the pipeline with stallreq until the access completes, then returns read data.
- It sits beside the MEM stage and feeds stallreq into the pipeline controller.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of 2, minimum 2.
- LATENCY, 2: wait cycles between accept and access, range 0..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- m_en  in  1  access request from the MEM stage.
- m_wen  in  4  byte write enables; 4'b0000 means read.
- m_vaddr  in  32  byte address.
- m_wdata  in  32  write data, byte lane i = bits [8i+7:8i].
- m_rdata  out  32  read data; valid in the DONE cycle of a read.
- stallreq  out  1  pipeline stall request.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, m_rdata=32'h0, stallreq=0.
  - Memory array is not reset; an in-flight access is dropped and no write occurs.
- States are IDLE, WAIT and DONE.
- IDLE:
  - If m_en=1, the request is accepted and stallreq=1 combinationally in the same cycle.
  - LATENCY=0: the access is performed at the accept edge, next state DONE.
  - LATENCY>0: cnt<=LATENCY at the accept edge, next state WAIT.
  - If m_en=0: stallreq=0 and the state is held.
- WAIT:
  - stallreq=1.
  - At each edge cnt decrements.
  - When cnt==1 at an edge, the access is performed and the next state is DONE.
- DONE:
  - stallreq=0 and m_rdata holds the word read.
  - m_en is ignored; this is the cycle the pipeline advances.
  - Next state is IDLE unconditionally.
- Access cost: LATENCY+1 stall cycles plus one DONE cycle.
- Requester rule: m_en, m_wen, m_vaddr and m_wdata must stay stable from accept through DONE. The responder samples them at the access edge, not the accept edge.
- Access:
  - Word index is m_vaddr[log2(DEPTH_WORDS)+1:2].
  - m_vaddr[1:0] and the upper address bits are ignored; addresses alias modulo DEPTH_WORDS*4.
  - Alignment exceptions are detected upstream.
- Write (m_wen≠0):
  - Only bytes with m_wen[i]=1 are updated.
  - m_rdata is loaded with the post-write word.
- Read (m_wen=0): m_rdata is loaded with the full word. Byte/halfword extraction is done by the MEM stage.
- m_rdata holds its value until the next access edge.
- No abort path: an accepted access always completes. A pipeline flush does not cancel it.
- Back-to-back requests: m_en held high through DONE yields one access only. The next request is accepted in the IDLE cycle that follows.

Decomposition:
- Shared defines header:
  - Widths: DataBus, AddrBus, ByteWEn.
  - Constants: ZeroWord, WrDisable.
  - State encodings: DMS_IDLE, DMS_WAIT, DMS_DONE (2-bit).
- Sub-module dmem_array:
  - Synchronous single-port RAM with 4 byte write enables.
  - Registered read port, write-first on the same address.
  - The FSM and counter stay in dmem_responder.

Test Plan:
- Reset: drive rst=0 with m_en=1 -> m_rdata=32'h0, stallreq=0; after release, the first accept occurs only on a cycle with m_en=1.
- Write then read (LATENCY=2):
  - Write 32'hDEADBEEF to 32'h00000010 with m_wen=4'b1111 -> stallreq=1 for exactly 3 cycles, 0 in DONE.
  - Then read 32'h00000010 -> m_rdata=32'hDEADBEEF in DONE.
- Byte write: on that word, m_wen=4'b0010 with m_wdata=32'h0000AA00 -> subsequent read returns 32'hDEADAAEF.
- Back-to-back reads:
  - m_en held high across two reads of 32'h10 and 32'h14 -> exactly two accesses, 4 cycles each.
  - stallreq pattern 1,1,1,0,1,1,1,0.
- Aliasing (DEPTH_WORDS=1024): write 32'h12345678 to 32'h00001010, then read 32'h00000013 -> 32'h12345678.
- Reset mid-write and LATENCY=0:
  - Assert rst in the WAIT cycle of a write to 32'h20 (prior value 32'h0) -> stallreq drops immediately; after release, a read of 32'h20 returns 32'h0.
  - With LATENCY=0, stall is 1 cycle per access.
